// File: rtl/rv32i_muldiv.sv
// rtl/rv32i_muldiv.sv - RV32M multiply/divide unit (iterative shift-add multiply, restoring divide)
//
// Optional feature macro: MULDIV_FAST_MUL_EN
//   defined   -> single-cycle full-width multiplier, MUL state lasts one cycle
//   undefined -> shift-add multiplier, one multiplier bit per cycle, XLEN cycles
//
// Ports:
//   i_clk, i_rst_n       clock, asynchronous active-low reset
//   i_start, i_funct3    request and RV32M op (0..3 multiply, 4..7 divide/remainder)
//   i_rs1, i_rs2         operands A and B
//   i_rd_addr            destination register carried through to o_rd_addr
//   i_flush              abort in-flight operation, no result produced
//   o_stall              high while the unit is busy (state not IDLE)
//   o_valid              one-cycle result strobe
//   o_y, o_rd_addr       result and its destination; held until the next o_valid
`timescale 1ns/1ps
module rv32i_muldiv #(
    parameter int XLEN = 32
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_start,
    input  logic [2:0]      i_funct3,
    input  logic [XLEN-1:0] i_rs1,
    input  logic [XLEN-1:0] i_rs2,
    input  logic [4:0]      i_rd_addr,
    input  logic            i_flush,
    output logic            o_stall,
    output logic            o_valid,
    output logic [XLEN-1:0] o_y,
    output logic [4:0]      o_rd_addr
);
    localparam int CW = $clog2(XLEN + 1);
    localparam logic [CW-1:0]   LAST_ITER = CW'(XLEN - 1);
    localparam logic [XLEN-1:0] MOST_NEG  = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

    state_t          state;
    logic [CW-1:0]   cnt;
    logic [2:0]      op;
    logic [4:0]      rd_q;
    // Multiply: acc_hi = running high half, acc_lo = multiplier shifting out / product low half.
    // Divide:   acc_hi = partial remainder, acc_lo = dividend shifting out / quotient shifting in.
    logic [XLEN-1:0] acc_hi;
    logic [XLEN-1:0] acc_lo;
    logic [XLEN-1:0] opnd_b;
    logic            sign_a;   // dividend sign, decides remainder sign
    logic            sign_x;   // operand signs differ, decides quotient/product sign

    // Operand decode at acceptance
    logic            rs1_signed, rs2_signed, a_neg, b_neg;
    logic [XLEN-1:0] a_mag, b_mag;
    logic            div_zero, div_ovf;

    assign rs1_signed = (i_funct3 == 3'd1) || (i_funct3 == 3'd2) ||
                        (i_funct3 == 3'd4) || (i_funct3 == 3'd6);
    assign rs2_signed = (i_funct3 == 3'd1) || (i_funct3 == 3'd4) || (i_funct3 == 3'd6);
    assign a_neg      = rs1_signed & i_rs1[XLEN-1];
    assign b_neg      = rs2_signed & i_rs2[XLEN-1];
    assign a_mag      = a_neg ? ({XLEN{1'b0}} - i_rs1) : i_rs1;
    assign b_mag      = b_neg ? ({XLEN{1'b0}} - i_rs2) : i_rs2;
    assign div_zero   = i_funct3[2] && (i_rs2 == {XLEN{1'b0}});
    // Signed overflow: only DIV (4) and REM (6) are signed divide ops
    assign div_ovf    = i_funct3[2] && !i_funct3[0] &&
                        (i_rs1 == MOST_NEG) && (i_rs2 == {XLEN{1'b1}});

    // Product of magnitudes as seen after the current MUL cycle
    logic [2*XLEN-1:0] prod;
`ifdef MULDIV_FAST_MUL_EN
    assign prod = {{XLEN{1'b0}}, acc_lo} * {{XLEN{1'b0}}, opnd_b};
`else
    logic [XLEN:0]   mul_sum;
    logic [XLEN-1:0] mul_hi_n, mul_lo_n;
    assign mul_sum  = {1'b0, acc_hi} + ({(XLEN+1){acc_lo[0]}} & {1'b0, opnd_b});
    assign mul_hi_n = mul_sum[XLEN:1];
    assign mul_lo_n = {mul_sum[0], acc_lo[XLEN-1:1]};
    assign prod     = {mul_hi_n, mul_lo_n};
`endif

    logic [2*XLEN-1:0] prod_s;
    logic [XLEN-1:0]   mul_res;
    assign prod_s  = sign_x ? ({(2*XLEN){1'b0}} - prod) : prod;
    assign mul_res = (op == 3'd0) ? prod_s[XLEN-1:0] : prod_s[2*XLEN-1:XLEN];

    // One restoring-division step: shift in the next dividend bit, try subtracting.
    logic [XLEN:0]   div_trial;
    logic            div_ok;
    logic [XLEN-1:0] div_rem_n, div_quo_n, div_res;
    assign div_trial = {acc_hi, acc_lo[XLEN-1]} - {1'b0, opnd_b};
    assign div_ok    = !div_trial[XLEN];
    assign div_rem_n = div_ok ? div_trial[XLEN-1:0] : {acc_hi[XLEN-2:0], acc_lo[XLEN-1]};
    assign div_quo_n = {acc_lo[XLEN-2:0], div_ok};
    assign div_res   = op[1] ? (sign_a ? ({XLEN{1'b0}} - div_rem_n) : div_rem_n)
                             : (sign_x ? ({XLEN{1'b0}} - div_quo_n) : div_quo_n);

    assign o_stall = (state != S_IDLE);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state     <= S_IDLE;
            cnt       <= '0;
            op        <= '0;
            rd_q      <= '0;
            acc_hi    <= '0;
            acc_lo    <= '0;
            opnd_b    <= '0;
            sign_a    <= 1'b0;
            sign_x    <= 1'b0;
            o_valid   <= 1'b0;
            o_y       <= '0;
            o_rd_addr <= '0;
        end else if (i_flush) begin
            state   <= S_IDLE;
            cnt     <= '0;
            o_valid <= 1'b0;
        end else begin
            o_valid <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (i_start) begin
                        op     <= i_funct3;
                        rd_q   <= i_rd_addr;
                        cnt    <= '0;
                        sign_a <= a_neg;
                        sign_x <= a_neg ^ b_neg;
                        acc_hi <= '0;
                        if (div_zero) begin
                            o_y       <= i_funct3[1] ? i_rs1 : {XLEN{1'b1}};
                            o_rd_addr <= i_rd_addr;
                            o_valid   <= 1'b1;
                            state     <= S_DONE;
                        end else if (div_ovf) begin
                            o_y       <= i_funct3[1] ? {XLEN{1'b0}} : i_rs1;
                            o_rd_addr <= i_rd_addr;
                            o_valid   <= 1'b1;
                            state     <= S_DONE;
                        end else if (i_funct3[2]) begin
                            acc_lo <= a_mag;
                            opnd_b <= b_mag;
                            state  <= S_DIV;
                        end else begin
                            acc_lo <= b_mag;
                            opnd_b <= a_mag;
                            state  <= S_MUL;
                        end
                    end
                end
                S_MUL: begin
`ifdef MULDIV_FAST_MUL_EN
                    o_y       <= mul_res;
                    o_rd_addr <= rd_q;
                    o_valid   <= 1'b1;
                    state     <= S_DONE;
`else
                    acc_hi <= mul_hi_n;
                    acc_lo <= mul_lo_n;
                    cnt    <= cnt + 1'b1;
                    if (cnt == LAST_ITER) begin
                        cnt       <= '0;
                        o_y       <= mul_res;
                        o_rd_addr <= rd_q;
                        o_valid   <= 1'b1;
                        state     <= S_DONE;
                    end
`endif
                end
                S_DIV: begin
                    acc_hi <= div_rem_n;
                    acc_lo <= div_quo_n;
                    cnt    <= cnt + 1'b1;
                    if (cnt == LAST_ITER) begin
                        cnt       <= '0;
                        o_y       <= div_res;
                        o_rd_addr <= rd_q;
                        o_valid   <= 1'b1;
                        state     <= S_DONE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_rv32i_muldiv.sv
// tb/tb_rv32i_muldiv.sv - self-checking bench for rv32i_muldiv
`timescale 1ns/1ps
module tb_rv32i_muldiv;
    localparam int XLEN = 32;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        flush = 1'b0;
    logic [2:0]  funct3 = '0;
    logic [31:0] rs1 = '0;
    logic [31:0] rs2 = '0;
    logic [4:0]  rd_addr = '0;
    logic        stall, valid;
    logic [31:0] y;
    logic [4:0]  rd_out;

    int          n_vec = 0;
    int          n_err = 0;
    logic [31:0] last_y = '0;

    always #5 clk = ~clk;

    rv32i_muldiv #(.XLEN(XLEN)) dut (
        .i_clk     (clk),
        .i_rst_n   (rst_n),
        .i_start   (start),
        .i_funct3  (funct3),
        .i_rs1     (rs1),
        .i_rs2     (rs2),
        .i_rd_addr (rd_addr),
        .i_flush   (flush),
        .o_stall   (stall),
        .o_valid   (valid),
        .o_y       (y),
        .o_rd_addr (rd_out)
    );

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // RV32M semantics from plain 64-bit arithmetic
    function automatic logic [31:0] ref_model(input logic [2:0] f, input logic [31:0] a,
                                              input logic [31:0] b);
        longint            sa, sb, q;
        longint unsigned   ua, ub;
        logic [63:0]       p;
        logic signed [65:0] psu;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'b0, a};
        ub = {32'b0, b};
        case (f)
            3'd0: begin p = ua * ub; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin
                psu = $signed({{34{a[31]}}, a}) * $signed({34'b0, b});
                return psu[63:32];
            end
            3'd3: begin p = ua * ub; return p[63:32]; end
            3'd4: begin if (b == 0) return 32'hFFFF_FFFF; q = sa / sb; return q[31:0]; end
            3'd5: begin if (b == 0) return 32'hFFFF_FFFF; return a / b; end
            3'd6: begin if (b == 0) return a; q = sa % sb; return q[31:0]; end
            default: begin if (b == 0) return a; return a % b; end
        endcase
    endfunction

    function automatic int ref_latency(input logic [2:0] f, input logic [31:0] a,
                                       input logic [31:0] b);
        if (f[2]) begin
            if (b == 0) return 1;
            if (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
            return XLEN + 1;
        end
`ifdef MULDIV_FAST_MUL_EN
        return 2;
`else
        return XLEN + 1;
`endif
    endfunction

    // Issue one op, scramble inputs after acceptance, optionally poke i_start while busy
    task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] rd, input bit poke);
        logic [31:0] exp_y;
        int          exp_lat, cyc, stall_cyc;
        bit          got;
        exp_y   = ref_model(f, a, b);
        exp_lat = ref_latency(f, a, b);
        @(negedge clk);
        check("idle_valid", {31'b0, valid}, 32'd0);
        check("idle_stall", {31'b0, stall}, 32'd0);
        start = 1'b1; funct3 = f; rs1 = a; rs2 = b; rd_addr = rd;
        @(posedge clk);
        #1;
        start = 1'b0; funct3 = 3'($urandom); rs1 = $urandom; rs2 = $urandom; rd_addr = 5'($urandom);
        cyc = 0; stall_cyc = 0; got = 0;
        while (!got && cyc < 60) begin
            @(negedge clk);
            cyc++;
            if (stall) stall_cyc++;
            if (valid) got = 1;
            if (poke && exp_lat > 4) begin
                if (cyc == 1) start = 1'b1;
                if (cyc == 3) start = 1'b0;
            end
        end
        start = 1'b0;
        check("latency", 32'(cyc), 32'(exp_lat));
        check("stall_cycles", 32'(stall_cyc), 32'(exp_lat));
        check("result", y, exp_y);
        check("rd_addr", {27'b0, rd_out}, {27'b0, rd});
        last_y = exp_y;
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0: return 32'h0000_0000;
            1: return 32'h0000_0001;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int nvalid;
        repeat (2) @(negedge clk);
        check("rst_y", y, 32'd0);
        check("rst_valid", {31'b0, valid}, 32'd0);
        check("rst_stall", {31'b0, stall}, 32'd0);
        check("rst_rd", {27'b0, rd_out}, 32'd0);
        rst_n = 1'b1;

        run_op(3'd0, 32'd7, 32'hFFFF_FFFD, 5'd1, 1'b0);
        check("mul_const", y, 32'hFFFF_FFEB);
        run_op(3'd1, 32'h8000_0000, 32'h8000_0000, 5'd2, 1'b1);
        check("mulh_const", y, 32'h4000_0000);
        run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3, 1'b0);
        check("mulhu_const", y, 32'hFFFF_FFFE);
        run_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd4, 1'b0);
        run_op(3'd4, 32'hFFFF_FFF9, 32'd2, 5'd5, 1'b1);
        check("div_const", y, 32'hFFFF_FFFD);
        run_op(3'd6, 32'hFFFF_FFF9, 32'd2, 5'd6, 1'b0);
        check("rem_const", y, 32'hFFFF_FFFF);
        run_op(3'd5, 32'd100, 32'd7, 5'd7, 1'b1);
        check("divu_const", y, 32'd14);
        run_op(3'd7, 32'd100, 32'd7, 5'd8, 1'b0);
        check("remu_const", y, 32'd2);
        run_op(3'd5, 32'd100, 32'd0, 5'd9, 1'b0);
        check("divu0_const", y, 32'hFFFF_FFFF);
        run_op(3'd7, 32'd100, 32'd0, 5'd10, 1'b0);
        check("remu0_const", y, 32'd100);
        run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd11, 1'b0);
        check("divovf_const", y, 32'h8000_0000);
        run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd12, 1'b0);
        check("removf_const", y, 32'd0);
        run_op(3'd5, 32'd100, 32'd7, 5'd13, 1'b0);

        // Flush at iteration 5 of a DIV, with a concurrent start that must be ignored
        @(negedge clk);
        start = 1'b1; funct3 = 3'd4; rs1 = 32'd1000; rs2 = 32'd3; rd_addr = 5'd20;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (5) @(negedge clk);
        flush = 1'b1; start = 1'b1; funct3 = 3'd5;
        @(posedge clk);
        #1 flush = 1'b0; start = 1'b0;
        @(negedge clk);
        check("flush_stall", {31'b0, stall}, 32'd0);
        check("flush_valid", {31'b0, valid}, 32'd0);
        nvalid = 0;
        repeat (40) begin @(negedge clk); if (valid) nvalid++; end
        check("flush_no_valid", 32'(nvalid), 32'd0);
        check("flush_y_kept", y, last_y);

        // Flush together with start in IDLE: not accepted
        @(negedge clk);
        flush = 1'b1; start = 1'b1; funct3 = 3'd5; rs1 = 32'd9; rs2 = 32'd3;
        @(negedge clk);
        check("flush_start_stall", {31'b0, stall}, 32'd0);
        flush = 1'b0; start = 1'b0;
        nvalid = 0;
        repeat (40) begin @(negedge clk); if (valid) nvalid++; end
        check("flush_start_no_valid", 32'(nvalid), 32'd0);

        // Asynchronous reset at iteration 10 of a DIVU
        @(negedge clk);
        start = 1'b1; funct3 = 3'd5; rs1 = 32'd12345; rs2 = 32'd7; rd_addr = 5'd17;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (9) @(negedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("arst_y", y, 32'd0);
        check("arst_valid", {31'b0, valid}, 32'd0);
        check("arst_stall", {31'b0, stall}, 32'd0);
        check("arst_rd", {27'b0, rd_out}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        last_y = '0;
        nvalid = 0;
        repeat (40) begin @(negedge clk); if (valid) nvalid++; end
        check("arst_no_valid", 32'(nvalid), 32'd0);
        run_op(3'd5, 32'd9, 32'd3, 5'd18, 1'b0);
        check("post_rst_divu", y, 32'd3);

        for (int i = 0; i < 40; i++) begin
            run_op(3'($urandom_range(0, 7)), pick(), pick(), 5'($urandom), 1'($urandom_range(0, 1)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
